// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers; one datapath step per clock, WIDTH steps per operation.
// Define MULDIV_DIVIDE_EN to build the restoring divider; without it DIV/DIVU complete immediately and leave HI/LO untouched.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc;      // partial product high half / partial remainder
    logic [WIDTH-1:0] mq;       // multiplier / dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] b_q;      // multiplicand / divisor magnitude
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             neg_res_q;
`ifdef MULDIV_DIVIDE_EN
    logic             is_div_q;
    logic             neg_rem_q;
    logic             dz_q;
    logic [WIDTH-1:0] a_raw_q;
`endif

    logic             op_signed;
    logic             last_step;
    logic [WIDTH-1:0] acc_nx, mq_nx;
    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] res_hi, res_lo;
`ifdef MULDIV_DIVIDE_EN
    logic [WIDTH:0]   div_shift, div_sub;
    logic             div_ge;
`endif

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    assign op_signed = ~op[0];
    assign last_step = (state == RUN) && (count == CW'(WIDTH - 1));

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;
`ifdef MULDIV_DIVIDE_EN
    assign div_by_zero = done & dz_q;
`else
    assign div_by_zero = 1'b0;
`endif

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                state_nx = IDLE;
                if (start) begin
`ifdef MULDIV_DIVIDE_EN
                    state_nx = RUN;
`else
                    state_nx = op[1] ? DONE : RUN;
`endif
                end
            end
            RUN:     if (last_step) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // One iteration: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        mul_sum = {1'b0, acc} + (mq[0] ? {1'b0, b_q} : {(WIDTH + 1){1'b0}});
        acc_nx  = mul_sum[WIDTH:1];
        mq_nx   = {mul_sum[0], mq[WIDTH-1:1]};
`ifdef MULDIV_DIVIDE_EN
        div_shift = {acc, mq[WIDTH-1]};
        div_sub   = div_shift - {1'b0, b_q};
        // The partial remainder stays below the divisor, so a set top bit means the subtract borrowed.
        div_ge    = ~div_sub[WIDTH];
        if (is_div_q) begin
            acc_nx = div_ge ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0];
            mq_nx  = {mq[WIDTH-2:0], div_ge};
        end
`endif
    end

    // Sign correction applied to the value produced by the final step.
    always_comb begin
        prod = {acc_nx, mq_nx};
        if (neg_res_q) prod = -prod;
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
`ifdef MULDIV_DIVIDE_EN
        if (is_div_q) begin
            res_lo = neg_res_q ? -mq_nx : mq_nx;
            res_hi = neg_rem_q ? -acc_nx : acc_nx;
            if (dz_q) begin
                res_hi = a_raw_q;
                res_lo = '1;
            end
        end
`endif
    end

    // NOTE: non-blocking assignments throughout, so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        // NOTE: the datapath registers are reset along with the architectural state so an aborted operation leaves nothing behind.
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            acc       <= '0;
            mq        <= '0;
            b_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_res_q <= 1'b0;
`ifdef MULDIV_DIVIDE_EN
            is_div_q  <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            a_raw_q   <= '0;
`endif
        end else begin
            state <= state_nx;
            if (state != RUN) begin
                if (hi_we) hi_q <= operand_a;
                if (lo_we) lo_q <= operand_a;
                if (start) begin
                    count     <= '0;
                    acc       <= '0;
                    mq        <= magnitude(operand_a, op_signed);
                    b_q       <= magnitude(operand_b, op_signed);
                    neg_res_q <= op_signed & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
`ifdef MULDIV_DIVIDE_EN
                    is_div_q  <= op[1];
                    neg_rem_q <= op_signed & operand_a[WIDTH-1];
                    dz_q      <= op[1] & (operand_b == '0);
                    a_raw_q   <= operand_a;
`endif
                end
            end else begin
                count <= count + CW'(1);
                acc   <= acc_nx;
                mq    <= mq_nx;
                if (last_step) begin
                    hi_q <= res_hi;
                    lo_q <= res_lo;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes model results, a monitor pops and compares on every done pulse.
// Expected values adapt to whether MULDIV_DIVIDE_EN is defined.
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic         hi_we;
    logic         lo_we;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    mul_div_unit #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           cycles;
        string        name;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: plain 64-bit arithmetic; SV '/' truncates toward zero and '%' follows the dividend sign.
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input string nm);
        exp_t   e;
        longint sa, sbv, p;
        e.name   = nm;
        e.dz     = 1'b0;
        e.hi     = m_hi;
        e.lo     = m_lo;
        e.cycles = W;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        case (o)
            2'b00: begin
                p = sa * sbv;
                {e.hi, e.lo} = p;
            end
            2'b01: {e.hi, e.lo} = {32'b0, a} * {32'b0, b};
            default: begin
`ifdef MULDIV_DIVIDE_EN
                if (b == '0) begin
                    e.hi = a;
                    e.lo = '1;
                    e.dz = 1'b1;
                end else if (o == 2'b10) begin
                    e.lo = W'(sa / sbv);
                    e.hi = W'(sa % sbv);
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
`else
                e.cycles = 0;
`endif
            end
        endcase
        return e;
    endfunction

    // Monitor: counts busy cycles and checks each done pulse against the scoreboard head.
    initial begin
        int   run;
        exp_t e;
        run = 0;
        forever begin
            @(negedge clock);
            if (busy) begin
                run++;
            end else if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'(0));
                end else begin
                    e = sb.pop_front();
                    check({e.name, " hi"}, 64'(hi), 64'(e.hi));
                    check({e.name, " lo"}, 64'(lo), 64'(e.lo));
                    check({e.name, " div_by_zero"}, 64'(div_by_zero), 64'(e.dz));
                    check({e.name, " busy_cycles"}, 64'(run), 64'(e.cycles));
                end
                run = 0;
            end else begin
                run = 0;
            end
            if (div_by_zero) check("dz_only_with_done", 64'(done), 64'(1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic hw, input logic lw, input string nm);
        exp_t e;
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        hi_we     = hw;
        lo_we     = lw;
        if (hw) m_hi = a;
        if (lw) m_lo = a;
        e = model(o, a, b, nm);
        sb.push_back(e);
        m_hi = e.hi;
        m_lo = e.lo;
        @(negedge clock);
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
    endtask

    task automatic wait_ready();
        int budget;
        budget = 100;
        while (busy && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        check("wait_ready_timeout", 64'(busy), 64'(0));
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string nm);
        issue(o, a, b, 1'b0, 1'b0, nm);
        wait_ready();
    endtask

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;
        logic         rhw, rlw;

        reset = 1'b1; start = 1'b0; op = 2'b00;
        operand_a = '0; operand_b = '0; hi_we = 1'b0; lo_we = 1'b0;
        repeat (3) @(negedge clock);
        check("reset hi", 64'(hi), 64'(0));
        check("reset lo", 64'(lo), 64'(0));
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset div_by_zero", 64'(div_by_zero), 64'(0));
        reset = 1'b0;
        @(negedge clock);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, "mult_neg3x7");
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "mult_min_x_neg1");
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, "div_neg7_2");
        run_op(2'b11, 32'd100, 32'd7, "divu_100_7");
        run_op(2'b11, 32'h0000_0064, 32'h0, "divu_by_zero");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_neg1");
        run_op(2'b10, 32'hFFFF_FF00, 32'h0, "div_neg_by_zero");
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, "div_7_neg2");

        // Inputs pulsed mid-operation must be ignored.
        issue(2'b00, 32'h1234_5678, 32'hFFFF_FF00, 1'b0, 1'b0, "ignored_inputs");
        repeat (9) @(negedge clock);
        start = 1'b1; op = 2'b01; operand_a = 32'hDEAD_BEEF; operand_b = 32'h5; hi_we = 1'b1;
        @(negedge clock);
        start = 1'b0; hi_we = 1'b0;
        wait_ready();
        @(negedge clock);

        operand_a = 32'h0000_1234; lo_we = 1'b1;
        @(negedge clock);
        lo_we = 1'b0;
        m_lo = 32'h0000_1234;
        check("mtlo lo", 64'(lo), 64'(m_lo));
        check("mtlo hi kept", 64'(hi), 64'(m_hi));
        operand_a = 32'hCAFE_0001; hi_we = 1'b1;
        @(negedge clock);
        hi_we = 1'b0;
        m_hi = 32'hCAFE_0001;
        check("mthi hi", 64'(hi), 64'(m_hi));
        check("mthi lo kept", 64'(lo), 64'(m_lo));

        // Reset mid-operation discards the result.
        issue(2'b10, 32'hFFFF_FF9C, 32'd7, 1'b0, 1'b0, "reset_abort");
        repeat (14) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort busy", 64'(busy), 64'(0));
        check("abort done", 64'(done), 64'(0));
        check("abort hi", 64'(hi), 64'(0));
        check("abort lo", 64'(lo), 64'(0));
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        reset = 1'b0;
        repeat (40) @(negedge clock);
        run_op(2'b10, 32'hFFFF_FF9C, 32'd7, "after_reset_div");

        // Randomised back-to-back traffic, occasionally with an MTHI/MTLO on the launch edge.
        for (int i = 0; i < 60; i++) begin
            ro  = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
            if ($urandom_range(0, 3) == 0) begin
                ra = W'($signed(8'($urandom)));
                rb = (rb == '0) ? '0 : W'($signed(5'($urandom)));
            end
            rhw = ($urandom_range(0, 5) == 0);
            rlw = ($urandom_range(0, 5) == 0);
            issue(ro, ra, rb, rhw, rlw, $sformatf("rand%0d_op%0d", i, ro));
            wait_ready();
        end
        repeat (3) @(negedge clock);
        check("scoreboard drained", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
